// File: rtl/channel_mux_pkg.sv
// Shared types and helpers for the channel scan multiplexer.
package channel_mux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DWELL   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // The scan ring never extends past the last physical channel.
    function automatic int eff_last(input int scan_last, input int num_ch);
        return (scan_last < num_ch - 1) ? scan_last : num_ch - 1;
    endfunction

endpackage

// File: rtl/channel_scan_mux_if.sv
// Control, channel bus and valid/ready sample port of the channel scan multiplexer.
interface channel_scan_mux_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CH      = 16,
    parameter int SEL_WIDTH   = 5,
    parameter int DWELL_WIDTH = 8
);
    logic [NUM_CH*DATA_WIDTH-1:0] in_bus;
    logic                         en;
    logic                         mode;
    logic [SEL_WIDTH-1:0]         sel;
    logic [SEL_WIDTH-1:0]         scan_last;
    logic [DWELL_WIDTH-1:0]       dwell;
    logic [DATA_WIDTH-1:0]        out;
    logic [SEL_WIDTH-1:0]         out_ch;
    logic                         out_err;
    logic                         out_valid;
    logic                         out_ready;
    logic                         busy;

    modport master (
        output in_bus, en, mode, sel, scan_last, dwell, out_ready,
        input  out, out_ch, out_err, out_valid, busy
    );

    modport slave (
        input  in_bus, en, mode, sel, scan_last, dwell, out_ready,
        output out, out_ch, out_err, out_valid, busy
    );
endinterface

// File: rtl/mux_n_select.sv
// Combinational NUM_CH:1 word selector from a flat bus; zero latency, no flow control.
// Out-of-range indices return zero data with in_range low.
module mux_n_select #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 16,
    parameter int SEL_WIDTH  = 5
) (
    input  logic [SEL_WIDTH-1:0]         idx,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_bus,
    output logic [DATA_WIDTH-1:0]        data,
    output logic                         in_range
);
    assign in_range = (int'(idx) < NUM_CH);

    always_comb begin
        data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == SEL_WIDTH'(k)) data = in_bus[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end
endmodule

// File: rtl/channel_scan_mux.sv
// Registered N:1 channel selector with manual/scan modes; capture DWELL+1 edges after start.
// Sample held on the valid/ready port until accepted; next dwell starts on the accept edge.
module channel_scan_mux
    import channel_mux_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CH      = 16,
    parameter int SEL_WIDTH   = 5,
    parameter int DWELL_WIDTH = 8
) (
    input  logic               core_clk,
    input  logic               rst,
    channel_scan_mux_if.slave  bus
);
    state_t                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   ch_q, ch_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  out_q, out_d;
    logic [SEL_WIDTH-1:0]   out_ch_q, out_ch_d;
    logic                   out_err_q, out_err_d;
    logic                   out_valid_q, out_valid_d;

    logic [DATA_WIDTH-1:0]  sel_dat;
    logic                   sel_in_range;
    logic [SEL_WIDTH-1:0]   next_ch;

    mux_n_select #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_CH     (NUM_CH),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_select (
        .idx      (ch_q),
        .in_bus   (bus.in_bus),
        .data     (sel_dat),
        .in_range (sel_in_range)
    );

    // A manual channel beyond the scan ring restarts the scan at channel 0.
    always_comb begin
        next_ch = bus.sel;
        if (bus.mode != MODE_MANUAL) begin
            if (int'(ch_q) >= eff_last(int'(bus.scan_last), NUM_CH)) next_ch = '0;
            else                                                      next_ch = ch_q + SEL_WIDTH'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    ch_d    = (bus.mode == MODE_SCAN) ? '0 : bus.sel;
                    cnt_d   = bus.dwell;
                    state_d = DWELL;
                end
            end
            DWELL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_WIDTH'(1);
                end else begin
                    out_d       = sel_dat;
                    out_ch_d    = ch_q;
                    out_err_d   = !sel_in_range;
                    out_valid_d = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (!bus.en) begin
                        state_d = IDLE;
                    end else begin
                        ch_d    = next_ch;
                        cnt_d   = bus.dwell;
                        state_d = DWELL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_ch_q    <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_channel_scan_mux.sv
// Directed plus randomized bench for channel_scan_mux against a channel-sequence model.
module tb_channel_scan_mux;
    localparam int DW  = 16;
    localparam int NCH = 16;
    localparam int SW  = 5;
    localparam int CW  = 8;

    logic core_clk;
    logic rst;

    channel_scan_mux_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .SEL_WIDTH(SW), .DWELL_WIDTH(CW)) bus_if ();

    channel_scan_mux #(.DATA_WIDTH(DW), .NUM_CH(NCH), .SEL_WIDTH(SW), .DWELL_WIDTH(CW)) dut (
        .core_clk (core_clk),
        .rst      (rst),
        .bus      (bus_if)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    int n_err    = 0;
    int n_checks = 0;

    logic [DW-1:0] chan [NCH];
    logic [DW-1:0] exp_out;
    int            exp_ch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic drive_bus();
        for (int k = 0; k < NCH; k++) bus_if.in_bus[k*DW +: DW] = chan[k];
    endtask

    task automatic randomize_bus();
        for (int k = 0; k < NCH; k++) chan[k] = DW'($urandom);
        drive_bus();
    endtask

    function automatic logic [DW-1:0] model_data(input int ch);
        return (ch < NCH) ? chan[ch] : '0;
    endfunction

    // Scan ring is 0..min(last, NCH-1); anything outside it restarts at 0.
    function automatic int model_next(input int prev, input bit scan, input int sel, input int last);
        int ring;
        if (!scan) return sel;
        ring = ((last < NCH - 1) ? last : NCH - 1) + 1;
        if (prev >= ring) return 0;
        return (prev + 1) % ring;
    endfunction

    task automatic scramble_ctrl();
        bus_if.mode      = 1'($urandom);
        bus_if.sel       = SW'($urandom);
        bus_if.scan_last = SW'($urandom);
        bus_if.dwell     = CW'($urandom);
        bus_if.en        = 1'($urandom);
    endtask

    task automatic set_ctrl(input bit en, input bit mode, input int sel, input int last, input int dw);
        bus_if.en        = en;
        bus_if.mode      = mode;
        bus_if.sel       = SW'(sel);
        bus_if.scan_last = SW'(last);
        bus_if.dwell     = CW'(dw);
    endtask

    // Called just after the edge that loaded the dwell count.
    task automatic do_sample(input int dw, input int ch, input bit scramble);
        for (int i = 0; i < dw; i++) begin
            if (scramble) scramble_ctrl();
            tick();
            chk("dwell_busy_valid", {30'd0, bus_if.busy, bus_if.out_valid}, 32'd2);
        end
        if (scramble) randomize_bus();
        exp_out = model_data(ch);
        exp_ch  = ch;
        tick();
        chk("cap_valid", bus_if.out_valid, 1);
        chk("cap_out", bus_if.out, exp_out);
        chk("cap_ch", bus_if.out_ch, ch);
        chk("cap_err", bus_if.out_err, (ch >= NCH) ? 1 : 0);
    endtask

    task automatic accept_tick();
        tick();
        chk("accept_valid", bus_if.out_valid, 0);
    endtask

    task automatic stall_check(input int n);
        for (int i = 0; i < n; i++) begin
            randomize_bus();
            scramble_ctrl();
            tick();
            chk("stall_valid", bus_if.out_valid, 1);
            chk("stall_out", bus_if.out, exp_out);
            chk("stall_ch", bus_if.out_ch, exp_ch);
        end
    endtask

    initial begin
        int prev;
        int mode_r, sel_r, last_r, dw_r;

        rst = 1'b1;
        set_ctrl(0, 0, 0, 0, 0);
        bus_if.out_ready = 1'b0;
        for (int k = 0; k < NCH; k++) chan[k] = DW'(16'h1000 + k);
        drive_bus();
        tick();
        tick();
        chk("rst_out", bus_if.out, 0);
        chk("rst_ch", bus_if.out_ch, 0);
        chk("rst_err", bus_if.out_err, 0);
        chk("rst_valid", bus_if.out_valid, 0);
        chk("rst_busy", bus_if.busy, 0);
        rst = 1'b0;

        // Manual SEL=5, DWELL=3: capture at edge 4, period 5.
        bus_if.out_ready = 1'b1;
        set_ctrl(1, 0, 5, 0, 3);
        tick();
        do_sample(3, 5, 0);
        chk("man_data", bus_if.out, 16'h1005);
        for (int r = 0; r < 2; r++) begin
            accept_tick();
            do_sample(3, 5, 0);
        end

        // Out-of-range manual channel.
        set_ctrl(1, 0, 20, 0, 3);
        accept_tick();
        do_sample(3, 20, 0);
        chk("oor_data", bus_if.out, 0);

        // Scan ring 0..3 with no dwell, switching from manual channel 20.
        set_ctrl(1, 1, 0, 3, 0);
        prev = 20;
        for (int r = 0; r < 6; r++) begin
            prev = model_next(prev, 1, 0, 3);
            accept_tick();
            do_sample(0, prev, 0);
        end
        chk("scan_last_ch", prev, 1);

        // Scan with SCAN_LAST beyond the channel count.
        set_ctrl(1, 1, 0, 31, 0);
        for (int r = 0; r < 20; r++) begin
            prev = model_next(prev, 1, 0, 31);
            accept_tick();
            do_sample(0, prev, 0);
        end

        // Backpressure: output held while IN_BUS and controls churn.
        bus_if.out_ready = 1'b0;
        stall_check(10);

        // EN dropped during a DWELL=5 sample.
        bus_if.out_ready = 1'b1;
        set_ctrl(1, 0, 7, 0, 5);
        accept_tick();
        bus_if.en = 1'b0;
        do_sample(5, 7, 0);
        tick();
        chk("endrop_valid", bus_if.out_valid, 0);
        chk("endrop_busy", bus_if.busy, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_quiet", {30'd0, bus_if.busy, bus_if.out_valid}, 0);
        end

        // Maximum dwell counts fully without wrapping.
        set_ctrl(1, 0, NCH - 1, 0, (1 << CW) - 1);
        tick();
        bus_if.en = 1'b0;
        do_sample((1 << CW) - 1, NCH - 1, 0);
        tick();
        chk("maxdw_idle", bus_if.busy, 0);

        // Randomized run with stalls and ignored mid-sample control changes.
        mode_r = $urandom_range(0, 1);
        sel_r  = $urandom_range(0, 31);
        last_r = $urandom_range(0, 31);
        dw_r   = $urandom_range(0, 6);
        set_ctrl(1, 1'(mode_r), sel_r, last_r, dw_r);
        tick();
        prev = mode_r ? 0 : sel_r;
        do_sample(dw_r, prev, 1);
        for (int r = 0; r < 25; r++) begin
            bus_if.out_ready = 1'b0;
            stall_check($urandom_range(0, 3));
            bus_if.out_ready = 1'b1;
            mode_r = $urandom_range(0, 1);
            sel_r  = $urandom_range(0, 31);
            last_r = $urandom_range(0, 31);
            dw_r   = $urandom_range(0, 6);
            set_ctrl(1, 1'(mode_r), sel_r, last_r, dw_r);
            prev = model_next(prev, 1'(mode_r), sel_r, last_r);
            accept_tick();
            chk("rand_busy", bus_if.busy, 1);
            do_sample(dw_r, prev, 1);
        end

        // Reset while a sample of 0x1234 is pending.
        chan[2] = 16'h1234;
        drive_bus();
        set_ctrl(1, 0, 2, 0, 1);
        accept_tick();
        bus_if.out_ready = 1'b0;
        do_sample(1, 2, 0);
        tick();
        chk("pend_out", bus_if.out, 16'h1234);
        rst = 1'b1;
        tick();
        chk("rstp_out", bus_if.out, 0);
        chk("rstp_ch", bus_if.out_ch, 0);
        chk("rstp_err", bus_if.out_err, 0);
        chk("rstp_valid", bus_if.out_valid, 0);
        chk("rstp_busy", bus_if.busy, 0);

        // Reset in mid-dwell.
        rst = 1'b0;
        set_ctrl(1, 0, 3, 0, 5);
        tick();
        tick();
        chk("mid_busy", bus_if.busy, 1);
        rst = 1'b1;
        tick();
        chk("rstd_busy", bus_if.busy, 0);
        chk("rstd_valid", bus_if.out_valid, 0);
        rst = 1'b0;
        bus_if.en = 1'b0;
        tick();
        chk("post_rst_idle", bus_if.busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
